mux_stream_n: RTL and testbench
===============================

MUX_STREAM_N -- requirements
Module: mux_stream_n

Interface
REQ-001 Parameter: WIDTH, default 4, data width per channel.
REQ-002 Parameter: NCH, default 4, number of input channels (2..16).
REQ-003 Parameter: MODE, default 0; 0 = external select, 1 = round-robin arbitration.
REQ-004 Parameter: SELW, default clog2(NCH), width of select/grant index.
REQ-005 Port: clk  in  1  single clock, all state rising-edge.
REQ-006 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 Port: sel  in  SELW  channel select, used only when MODE=0.
REQ-008 Port: in_data  in  NCH*WIDTH  flattened channel data, channel i at bits [i*WIDTH +: WIDTH].
REQ-009 Port: in_valid  in  NCH  per-channel valid.
REQ-010 Port: in_ready  out  NCH  per-channel ready; at most one bit high per cycle.
REQ-011 Port: y  out  WIDTH  registered output data.
REQ-012 Port: y_valid  out  1  output holds an untaken beat.
REQ-013 Port: y_ready  in  1  downstream accepts y this cycle.
REQ-014 Port: y_ch  out  SELW  index of the channel that sourced y.

Function
REQ-015 Output register SHALL load when (!y_valid || y_ready) and a grant exists; load_en = that first term.
REQ-016 Transfer on channel i SHALL occur iff in_valid[i] && in_ready[i]; in_ready[i] = grant[i] && load_en.
REQ-017 MODE=0: grant SHALL be channel sel if sel < NCH and in_valid[sel]; sel >= NCH SHALL grant nothing.
REQ-018 MODE=1: grant SHALL be the first valid channel at or after pointer ptr, searching upward with wrap from NCH-1 to 0.
REQ-019 MODE=1: after a transfer on channel g, ptr SHALL become g+1, wrapping to 0 when g = NCH-1; ptr SHALL hold otherwise.
REQ-020 Latency SHALL be one cycle: a beat transferred at edge k appears on y/y_valid after edge k.
REQ-021 On load, y <= in_data channel g, y_ch <= g, y_valid <= 1.
REQ-022 If y_ready && y_valid and no grant, y_valid SHALL clear; y and y_ch SHALL hold their last value.
REQ-023 If !y_valid, y_valid SHALL stay 0 until a grant; simultaneous drain and load SHALL give back-to-back beats with no bubble.
REQ-024 When y_valid && !y_ready, y, y_ch, y_valid SHALL hold and all in_ready SHALL be 0.
REQ-025 Grant SHALL depend only on current in_valid, sel and ptr, never on in_data; in_ready SHALL not depend on in_valid of non-granted channels in MODE=0.
REQ-026 Changing sel while y is stalled SHALL not affect y; new sel applies at the next load.

Reset
REQ-027 While rst_n=0: y_valid=0, y=0, y_ch=0, ptr=0, all in_ready=0, asynchronously.
REQ-028 Reset asserted mid-transfer SHALL discard the held beat; first load after release follows REQ-015..019 with ptr=0.
REQ-029 Reset release SHALL be consumed synchronously; first state change no earlier than the first edge with rst_n=1.

Structure
REQ-030 Shared package mux_pkg SHALL hold MODE constants (MODE_SEL=0, MODE_RR=1) and the clog2 function.
REQ-031 Round-robin search SHALL live in sub-module rr_arbiter (inputs req, ptr; output one-hot grant, grant index, any); MODE=0 bypasses it.
REQ-032 No latches; all outputs SHALL come from flops except in_ready.

Verification (WIDTH=4, NCH=4)
REQ-033 MODE=0, sel=2, in_valid=4'b0100, channel 2 data=4'hA, y_ready=1 -> in_ready=4'b0100, next cycle y=4'hA, y_ch=2, y_valid=1.
REQ-034 MODE=1, all valid, y_ready=1, data ch i = i+1 -> y sequence 1,2,3,4,1 on consecutive cycles, y_ch 0,1,2,3,0.
REQ-035 MODE=1, ptr=3, valid=4'b0011 -> grant ch 0 (wrap), then ch 1, ptr ends at 2.
REQ-036 y_valid=1, y_ready=0 for 3 cycles with inputs toggling -> y, y_ch constant, in_ready=0; on y_ready=1 with pending valid -> new beat next cycle, no bubble.
REQ-037 MODE=0, sel=2, in_valid=4'b1011 -> no grant, in_ready=0; y_valid drops after the held beat is taken.
REQ-038 Assert rst_n=0 mid-stream with y_valid=1 -> y_valid=0, ptr=0 immediately without a clock edge; after release, all valid -> first y_ch=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer.
// Selection modes and a ceiling-log2 usable in parameter defaults.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr, wrapping
// from NCH-1 back to 0. Purely combinational.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] grant_idx,
    output logic            any
);

    int c;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        c         = 0;
        for (int k = 0; k < NCH; k++) begin
            c = (int'(ptr) + k) % NCH;
            if (!any && req[c]) begin
                any       = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = SELW'(c);
            end
        end
    end

endmodule

// File: rtl/mux_stream_n.sv
// N-channel valid/ready stream multiplexer with a one-deep registered output,
// channel chosen by external select (MODE_SEL) or round-robin (MODE_RR).
module mux_stream_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int MODE  = MODE_SEL,
    parameter int SELW  = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     y,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic [SELW-1:0]      y_ch
);

    logic [WIDTH-1:0] y_q, y_d;
    logic [SELW-1:0]  y_ch_q, y_ch_d;
    logic             y_valid_q, y_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  grant_idx;
    logic             any;
    logic             load_en;
    logic             load;
    logic [WIDTH-1:0] grant_data;

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(
                .NCH  (NCH),
                .SELW (SELW)
            ) u_arb (
                .req       (in_valid),
                .ptr       (ptr_q),
                .grant     (grant),
                .grant_idx (grant_idx),
                .any       (any)
            );
        end else begin : g_sel
            // Compare sel against each index so an out-of-range sel simply
            // matches nothing, and only the selected channel's valid matters.
            always_comb begin
                grant     = '0;
                grant_idx = '0;
                any       = 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    if (sel == SELW'(i) && in_valid[i]) begin
                        grant[i]  = 1'b1;
                        grant_idx = SELW'(i);
                        any       = 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign load_en  = !y_valid_q || y_ready;
    assign load     = load_en && any;
    // rst_n gates ready so no handshake can complete while reset is held.
    assign in_ready = grant & {NCH{load_en && rst_n}};

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        y_d       = y_q;
        y_ch_d    = y_ch_q;
        y_valid_d = y_valid_q;
        ptr_d     = ptr_q;
        if (load) begin
            y_d       = grant_data;
            y_ch_d    = grant_idx;
            y_valid_d = 1'b1;
            if (MODE == MODE_RR) begin
                ptr_d = (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + SELW'(1);
            end
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            y_q       <= y_d;
            y_ch_q    <= y_ch_d;
            y_valid_q <= y_valid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_stream_n.sv
// Bench for mux_stream_n: one select-mode and one round-robin instance,
// directed scenarios plus random traffic against a transaction-level model.
module tb_mux_stream_n;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk;
    logic rst_n;

    logic [SW-1:0]  sel_a  [2];
    logic [N*W-1:0] dat_a  [2];
    logic [N-1:0]   val_a  [2];
    logic [N-1:0]   rdy_a  [2];
    logic [W-1:0]   y_a    [2];
    logic           yv_a   [2];
    logic           yr_a   [2];
    logic [SW-1:0]  ych_a  [2];

    // Reference state: the beat held at the output and the round-robin pointer.
    int m_y   [2];
    int m_ch  [2];
    bit m_v   [2];
    int m_ptr [2];

    int n_chk;
    int n_err;

    mux_stream_n #(.WIDTH(W), .NCH(N), .MODE(0)) u_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel_a[0]),
        .in_data  (dat_a[0]),
        .in_valid (val_a[0]),
        .in_ready (rdy_a[0]),
        .y        (y_a[0]),
        .y_valid  (yv_a[0]),
        .y_ready  (yr_a[0]),
        .y_ch     (ych_a[0])
    );

    mux_stream_n #(.WIDTH(W), .NCH(N), .MODE(1)) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel_a[1]),
        .in_data  (dat_a[1]),
        .in_valid (val_a[1]),
        .in_ready (rdy_a[1]),
        .y        (y_a[1]),
        .y_valid  (yv_a[1]),
        .y_ready  (yr_a[1]),
        .y_ch     (ych_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel chosen by the rules: select mode takes sel if valid; round-robin
    // scans upward from ptr with wrap. -1 means no grant.
    function automatic int pick(input int mode, input int s, input logic [N-1:0] v, input int p);
        if (mode == 0) begin
            if (s < N && v[s]) return s;
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_y[m]   = 0;
            m_ch[m]  = 0;
            m_v[m]   = 1'b0;
            m_ptr[m] = 0;
        end
    endtask

    // Entered just after a rising edge with inputs already driven; checks
    // in_ready mid-cycle, then the registered outputs just after the next edge.
    task automatic step();
        int g  [2];
        bit le [2];
        logic [N-1:0] exp_rdy;
        #1;
        for (int m = 0; m < 2; m++) begin
            le[m] = !m_v[m] || yr_a[m];
            g[m]  = pick(m, int'(sel_a[m]), val_a[m], m_ptr[m]);
            exp_rdy = (rst_n && le[m] && g[m] >= 0) ? N'(1 << g[m]) : '0;
            check($sformatf("in_ready[%0d]", m), 32'(rdy_a[m]), 32'(exp_rdy));
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                // held in reset: nothing changes
            end else if (le[m] && g[m] >= 0) begin
                m_y[m]  = int'(dat_a[m][g[m]*W +: W]);
                m_ch[m] = g[m];
                m_v[m]  = 1'b1;
                if (m == 1) m_ptr[m] = (g[m] + 1) % N;
            end else if (yr_a[m]) begin
                m_v[m] = 1'b0;
            end
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            $display("step t=%0t dut=%0d sel=%0d valid=%b yr=%b -> y=%h ch=%0d yv=%b",
                     $time, m, sel_a[m], val_a[m], yr_a[m], y_a[m], ych_a[m], yv_a[m]);
            check($sformatf("y_valid[%0d]", m), 32'(yv_a[m]), 32'(m_v[m]));
            check($sformatf("y[%0d]", m), 32'(y_a[m]), 32'(m_y[m]));
            check($sformatf("y_ch[%0d]", m), 32'(ych_a[m]), 32'(m_ch[m]));
        end
    endtask

    task automatic drive(input int m, input int s, input logic [N-1:0] v,
                         input logic [N*W-1:0] d, input logic r);
        sel_a[m] = SW'(s);
        val_a[m] = v;
        dat_a[m] = d;
        yr_a[m]  = r;
    endtask

    task automatic drive_rand(input int m, input int ready_pct);
        sel_a[m] = SW'($urandom);
        val_a[m] = N'($urandom);
        dat_a[m] = (N*W)'($urandom);
        yr_a[m]  = ($urandom_range(0, 99) < ready_pct);
    endtask

    int hold_y;
    int hold_ch;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, '0, '0, 1'b0);
        drive(1, 0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check("reset_y_valid", 32'(yv_a[m]), 32'(0));
            check("reset_y", 32'(y_a[m]), 32'(0));
            check("reset_y_ch", 32'(ych_a[m]), 32'(0));
            check("reset_in_ready", 32'(rdy_a[m]), 32'(0));
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Select mode, single channel.
        drive(0, 2, 4'b0100, 16'h0A00, 1'b1);
        drive(1, 0, 4'b0000, 16'h0000, 1'b1);
        step();
        check("sel_y_A", 32'(y_a[0]), 32'hA);
        check("sel_ych_2", 32'(ych_a[0]), 32'd2);
        check("sel_yv_1", 32'(yv_a[0]), 32'd1);

        // Selected channel not valid: held beat drains, then output empties.
        drive(0, 2, 4'b1011, 16'h5555, 1'b1);
        step();
        check("nogrant_yv_0", 32'(yv_a[0]), 32'd0);
        check("nogrant_y_hold", 32'(y_a[0]), 32'hA);

        // Stall with toggling inputs, then restart without a bubble.
        drive(0, 0, 4'b0001, 16'h0007, 1'b1);
        step();
        hold_y  = m_y[0];
        hold_ch = m_ch[0];
        for (int i = 0; i < 3; i++) begin
            drive_rand(0, 0);
            step();
            check("stall_y", 32'(y_a[0]), 32'(hold_y));
            check("stall_ych", 32'(ych_a[0]), 32'(hold_ch));
        end
        drive(0, 1, 4'b0010, 16'h0050, 1'b1);
        step();
        check("restart_y", 32'(y_a[0]), 32'h5);
        check("restart_ych", 32'(ych_a[0]), 32'd1);
        check("restart_yv", 32'(yv_a[0]), 32'd1);

        // Round-robin over all channels.
        drive(0, 0, 4'b0000, 16'h0000, 1'b1);
        drive(1, 0, 4'b1111, 16'h4321, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_seq_y", 32'(y_a[1]), 32'((i % N) + 1));
            check("rr_seq_ch", 32'(ych_a[1]), 32'(i % N));
        end

        // Move the pointer to 3, then requests only below it must wrap.
        drive(1, 0, 4'b0100, 16'h4321, 1'b1);
        step();
        drive(1, 0, 4'b0011, 16'h4321, 1'b1);
        step();
        check("rr_wrap_ch0", 32'(ych_a[1]), 32'd0);
        step();
        check("rr_wrap_ch1", 32'(ych_a[1]), 32'd1);
        drive(1, 0, 4'b1111, 16'h4321, 1'b1);
        step();
        check("rr_ptr_2", 32'(ych_a[1]), 32'd2);

        for (int i = 0; i < 400; i++) begin
            drive_rand(0, 70);
            drive_rand(1, 70);
            step();
        end

        // Asynchronous reset while both outputs hold a beat.
        drive(0, 3, 4'b1111, 16'h9876, 1'b0);
        drive(1, 0, 4'b1111, 16'h9876, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            check("async_rst_yv", 32'(yv_a[m]), 32'(0));
            check("async_rst_y", 32'(y_a[m]), 32'(0));
            check("async_rst_ych", 32'(ych_a[m]), 32'(0));
        end
        yr_a[0] = 1'b1;
        yr_a[1] = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_rr_ch0", 32'(ych_a[1]), 32'd0);
        check("post_rst_sel_ch3", 32'(ych_a[0]), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
